frame_buf_multi: RTL
====================

# frame_buf_multi

Single-clock, N-buffered frame store. It generalises the single-frame buffer to NUM_BUFS independent frame slots with parameterised data width and frame depth. A producer fills frames in round-robin order while a consumer drains completed frames in the same order. Each slot is claimed, filled, handed off and released with explicit ready/available flags, so neither side can overrun or under-read the other. It sits between the pixel/sample producer and the downstream consumer.

## Interface
- DATA_WIDTH, 32, word width in bits
- ADDR_WIDTH, 3, per-frame address width
- MEM_DEPTH, 1 << ADDR_WIDTH, words per frame
- NUM_BUFS, 2, number of frame slots (legal range 1..8; need not be a power of 2)
- BUF_W, max(1, clog2(NUM_BUFS)), slot index width (derived)
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- wr_en_in  in  1  write strobe, active-high; word is accepted when wr_en_in && wr_rdy
- data_in  in  DATA_WIDTH  write data
- wr_rdy  out  1  current write slot is free
- wr_frame_done  out  1  one-cycle pulse after the last word of a frame is accepted
- rd_en_in  in  1  read strobe, active-high; read is accepted when rd_en_in && rd_avail
- rd_avail  out  1  current read slot holds a complete frame
- data_out  out  DATA_WIDTH  read data
- rd_valid  out  1  data_out is valid this cycle
- rd_last  out  1  qualifies the last word of a frame; high only with rd_valid
- frames_full  out  clog2(NUM_BUFS+1)  count of complete, unreleased frames

## Operation
- Storage: NUM_BUFS*MEM_DEPTH words.
  - Physical address = slot*MEM_DEPTH + offset.
  - Address width = ADDR_WIDTH + BUF_W.
- Per-slot full flag, full[NUM_BUFS-1:0].
- Write side:
  - Registers: wr_buf (slot) and wr_addr (offset).
  - wr_rdy = ~full[wr_buf].
  - Each accepted write stores data_in and increments wr_addr.
  - When the word at wr_addr == MEM_DEPTH-1 is accepted:
    - full[wr_buf] is set.
    - wr_addr returns to 0.
    - wr_buf advances; NUM_BUFS-1 wraps to 0.
    - wr_frame_done pulses on the next cycle.
  - A wr_en_in while wr_rdy is low is ignored: no write and no pointer change.
- Read FSM states: R_IDLE (no word of the current frame consumed) and R_READ (mid-frame).
  - R_IDLE -> R_READ on the first accepted read of a frame.
  - R_READ -> R_IDLE on acceptance of the word at offset MEM_DEPTH-1.
  - rd_avail = full[rd_buf]. It stays high for the whole frame being drained.
  - Each accepted read fetches slot rd_buf, offset rd_addr, then increments rd_addr.
  - On acceptance of the last word:
    - full[rd_buf] is cleared.
    - rd_addr returns to 0.
    - rd_buf advances with the same wrap rule as wr_buf.
- Counter:
  - frames_full increments on a frame complete and decrements on a frame release.
  - Both events in the same cycle leave it unchanged.
  - It never exceeds NUM_BUFS and never underflows.
- Reset (any cycle, including mid-frame):
  - All full flags cleared; wr_buf, wr_addr, rd_buf and rd_addr set to 0; FSM to R_IDLE.
  - Partially written or partially read frames are discarded.
  - Memory contents are not cleared.

## Timing
- Reset values on the cycle after reset is sampled high:
  - wr_rdy = 1
  - rd_avail = 0, rd_valid = 0, rd_last = 0, wr_frame_done = 0
  - data_out = 0, frames_full = 0
- Read latency is 1 cycle. A read accepted at cycle N gives data_out, rd_valid and rd_last at N+1.
- data_out holds its last value while rd_valid = 0.
- Frame handoff: the last write accepted at N gives full set at the edge ending N, so rd_avail = 1 and frames_full is updated at N+1.
- Release: the last read accepted at N gives that slot free at N+1. The writer may claim the slot no earlier than N+1.
- Back-to-back operation:
  - Writes of one word per cycle are sustained across frame boundaries whenever the next slot is free.
  - Reads are sustained the same way whenever the next slot is full.
- Simultaneous write and read in the same cycle are always legal because they address different slots.
- NUM_BUFS = 1 degenerates to strict fill-then-drain.

## Test plan
- Reset, then 8 writes of 0x10..0x17 (DEPTH 8, NUM_BUFS 2) -> wr_frame_done pulse; rd_avail = 1 and frames_full = 1 one cycle after the last write. Then 8 reads -> data_out 0x10..0x17, one cycle after each read; rd_last with 0x17; rd_avail = 0 after.
- Write 16 words with no reads -> wr_rdy = 0 after word 16 and frames_full = 2. A 17th wr_en_in is ignored. Read one frame -> wr_rdy = 1 exactly one cycle after the last read is accepted.
- NUM_BUFS = 3, continuous write and read for 5 frames -> slot index wraps 2->0. Data comes out in order with no loss or duplication; frames_full stays within 0..3.
- Frame completion and frame release in the same cycle (frames_full = 1 before) -> frames_full stays 1; both flags update correctly next cycle.
- Reset after 5 words of frame 0 and 3 reads of a full frame 1 -> all outputs at reset values next cycle. A fresh 8-word frame then reads back intact from slot 0.
- rd_en_in held high with rd_avail = 0 -> rd_valid stays 0 and rd_addr is unchanged.

Source files
------------

// File: rtl/frame_buf_multi.sv
// frame_buf_multi: NUM_BUFS-slot round-robin frame store with per-slot full flags
// handing complete frames from a producer to a consumer.
module frame_buf_multi #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int MEM_DEPTH  = 1 << ADDR_WIDTH,
    parameter int NUM_BUFS   = 2,
    parameter int BUF_W      = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1,
    parameter int CNT_W      = $clog2(NUM_BUFS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  wr_rdy,
    output logic                  wr_frame_done,
    input  logic                  rd_en_in,
    output logic                  rd_avail,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  rd_last,
    output logic [CNT_W-1:0]      frames_full
);
    localparam logic [ADDR_WIDTH-1:0] LAST_OFF = ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam logic [BUF_W-1:0]      LAST_BUF = BUF_W'(NUM_BUFS - 1);
    typedef enum logic {R_IDLE, R_READ} rstate_t;
    rstate_t state_q, state_d;
    logic [NUM_BUFS-1:0] full_q, full_d;
    logic [BUF_W-1:0] wr_buf_q, wr_buf_d, rd_buf_q, rd_buf_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d, rd_off;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic valid_q, valid_d, last_q, last_d, done_q, done_d;
    logic wr_acc, rd_acc, wr_end, rd_end;
    logic [DATA_WIDTH-1:0] mem [NUM_BUFS*MEM_DEPTH];

    assign wr_rdy        = ~full_q[wr_buf_q];
    assign rd_avail      = full_q[rd_buf_q];
    assign wr_frame_done = done_q;
    assign data_out      = data_q;
    assign rd_valid      = valid_q;
    assign rd_last       = last_q;
    assign frames_full   = cnt_q;

    always_comb begin
        wr_acc    = wr_en_in && wr_rdy;
        rd_acc    = rd_en_in && rd_avail;
        // an idle reader has consumed nothing of the current frame, so it is at offset 0
        rd_off    = (state_q == R_IDLE) ? '0 : rd_addr_q;
        wr_end    = wr_acc && (wr_addr_q == LAST_OFF);
        rd_end    = rd_acc && (rd_off == LAST_OFF);
        wr_addr_d = wr_end ? '0 : wr_addr_q + ADDR_WIDTH'(wr_acc);
        rd_addr_d = rd_end ? '0 : rd_off + ADDR_WIDTH'(rd_acc);
        wr_buf_d  = !wr_end ? wr_buf_q : (wr_buf_q == LAST_BUF) ? '0 : wr_buf_q + 1'b1;
        rd_buf_d  = !rd_end ? rd_buf_q : (rd_buf_q == LAST_BUF) ? '0 : rd_buf_q + 1'b1;
        full_d    = full_q;
        if (wr_end) full_d[wr_buf_q] = 1'b1;
        if (rd_end) full_d[rd_buf_q] = 1'b0;
        cnt_d     = cnt_q + CNT_W'(wr_end) - CNT_W'(rd_end);
        state_d   = !rd_acc ? state_q : rd_end ? R_IDLE : R_READ;
        data_d    = rd_acc ? mem[{rd_buf_q, rd_off}] : data_q;
        valid_d   = rd_acc;
        last_d    = rd_end;
        done_d    = wr_end;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= R_IDLE;
            full_q    <= '0;
            wr_buf_q  <= '0;
            rd_buf_q  <= '0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            full_q    <= full_d;
            wr_buf_q  <= wr_buf_d;
            rd_buf_q  <= rd_buf_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            done_q    <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[{wr_buf_q, wr_addr_q}] <= data_in;
    end
endmodule
